hazard_forward_unit: RTL and testbench
======================================

Name: hazard_forward_unit

Overview:
- Producer end of the execute-stage operand-forwarding interface.
- Tracks in-flight register writers in a 3-entry scoreboard that mirrors the EX, MEM and WB pipeline positions.
- Generates the registered FU_Src_Sel/FU_Dst_Sel codes consumed by the execute stage, and raises a load-use stall toward fetch/decode.
- Sits between the decode stage and the ID/EX pipeline register.

Parameters:
- RA_W, 3, register address width (8 GPRs).
- LOAD_STALL, 1, bubbles inserted per load-use hazard (1..3).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- id_valid  in  1  decode holds a real instruction.
- id_src_addr  in  RA_W  Rsrc address.
- id_dst_addr  in  RA_W  Rdst address.
- id_uses_src  in  1  instruction reads Rsrc through operand A.
- id_uses_dst  in  1  instruction reads Rdst through operand B.
- id_wr_en  in  1  instruction writes a GPR.
- id_wr_addr  in  RA_W  GPR written.
- id_is_load  in  1  written value comes from memory.
- pipe_hold  in  1  downstream stall; freeze everything.
- flush  in  1  squash the instruction entering EX.
- fu_src_sel  out  2  operand-A forward select, aligned to EX.
- fu_dst_sel  out  2  operand-B forward select, aligned to EX.
- stall  out  1  hold PC and IF/ID; combinational.
- ex_bubble  out  1  EX slot currently holds an injected bubble.

Behaviour:
- Select encoding (shared):
  - 00: no forward.
  - 01: WB bus.
  - 10: ALU result in EX/MEM.
  - 11: ALU result in MEM/WB.
- fu_dst_sel never takes 11.
- Scoreboard: entries E, M and W, each holding {valid, wr_addr, is_load}.
- Each unheld edge:
  - W <= M.
  - M <= E.
  - E <= the decode entry. This is a bubble (valid=0) when stall, flush or !id_valid is asserted, or when id_wr_en=0.
- Select computation, at the decode cycle, registered into fu_*_sel on the same edge the instruction enters EX:
  - Match against current E (one ahead, becomes M): src=10, dst=10.
  - Else match against current M (two ahead, becomes W):
    - Load: src=01, dst=01.
    - Non-load: src=11, dst=01.
  - Else 00.
  - The newest match wins.
  - A match requires entry valid, equal address and the relevant id_uses_* bit set.
  - Writers three or more ahead are resolved by register-file write-before-read and are out of scope.
- Load-use hazard:
  - Condition: E.valid & E.is_load & the decode operand matches E.wr_addr.
  - stall=1 for LOAD_STALL cycles, counted by an internal counter.
  - During each of those cycles a bubble enters E and fu_*_sel register 00.
  - After the last stall cycle the decode instruction re-evaluates. Its producer is now further ahead and gets the matching 01/11 code; for LOAD_STALL>1 this resolves to 00 via the register file.
- Hazard on both operands against the same load produces a single stall window, not two.
- pipe_hold=1:
  - Scoreboard, stall counter and fu_*_sel all hold.
  - stall output is forced 1.
  - pipe_hold has priority over flush.
- flush=1 (no hold):
  - E becomes a bubble.
  - fu_*_sel <= 00, ex_bubble <= 1.
  - The stall counter clears.
  - Flush overrides a simultaneous load-use stall.
- ex_bubble is registered and is 1 whenever E was loaded with a bubble.
- Reset (rst=0, asynchronous):
  - All entries invalid, counter 0.
  - fu_src_sel=00, fu_dst_sel=00, ex_bubble=1.
  - stall=0 (it is combinational from invalid state).
  - Reset mid-stall abandons the stall immediately.
- Address 0 is an ordinary register, not hard-wired; it forwards normally.

Decomposition:
- Shared package/include: FU select encodings (FWD_NONE=00, FWD_WB=01, FWD_EM=10, FWD_MW=11) and the scoreboard entry field layout.
- The execute stage includes the same constants.
- One sub-module, sb_entry_reg: a valid/addr/is_load register with hold and clear. It is instantiated three times.

Test Plan:
- ADD R1 then ADD R2,R1 back-to-back -> second instruction in EX sees fu_src_sel=10; no stall.
- ADD R3, NOP, then SUB R4,R3 (R3 as Rdst operand) -> fu_dst_sel=01, fu_src_sel=00.
- ADD R5, NOP, then OR using R5 as Rsrc -> fu_src_sel=11.
- LDD R6 then ADD R7,R6 -> stall=1 for exactly 1 cycle, ex_bubble=1 that cycle, then fu_src_sel=01; with LOAD_STALL=2 the stall lasts 2 cycles, then 00.
- Load-use stall with flush in the same cycle -> stall drops next cycle, E is a bubble, selects 00; pipe_hold for 3 cycles mid-sequence -> outputs frozen, then the sequence resumes unchanged.
- Assert rst low asynchronously during a stall -> stall=0, selects 00, ex_bubble=1 before the next clock edge.

Source files
------------

// File: rtl/hazard_forward_unit_pkg.sv
// Shared forwarding constants: FU select codes and scoreboard entry field layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package hazard_forward_unit_pkg;

  // Operand forward select codes, shared with the execute-stage operand muxes.
  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,  // take the register-file value
    FWD_WB   = 2'b01,  // take the write-back bus
    FWD_EM   = 2'b10,  // take the ALU result held in EX/MEM
    FWD_MW   = 2'b11   // take the ALU result held in MEM/WB
  } fwd_sel_e;

  // Scoreboard entry layout, packed as {wr_addr, is_load, valid}.
  localparam int SB_VALID_BIT = 0;
  localparam int SB_LOAD_BIT  = 1;
  localparam int SB_ADDR_LSB  = 2;
  localparam int SB_META_W    = 2;

  // Load-use stall counter width; covers stall windows of up to 4 bubbles.
  localparam int STALL_CNT_W  = 2;

  // A writer two ahead of decode reaches operand A from MEM/WB if it is an
  // ALU op, but a load's data only appears on the write-back bus.
  function automatic fwd_sel_e mw_src_code(input logic is_load);
    return is_load ? FWD_WB : FWD_MW;
  endfunction

endpackage

// File: rtl/sb_entry_reg.sv
// One scoreboard slot: registered {wr_addr, is_load, valid} for an in-flight writer.
// Latency: 1 cycle from entry_i to entry_o.
// Backpressure: hold_i freezes the slot; clear_i loads an all-zero (invalid) entry.
module sb_entry_reg
  import hazard_forward_unit_pkg::*;
#(
  parameter int RA_W = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      hold_i,
  input  logic                      clear_i,
  input  logic [RA_W+SB_META_W-1:0] entry_i,
  output logic [RA_W+SB_META_W-1:0] entry_o
);

  logic [RA_W+SB_META_W-1:0] entry_q;
  logic [RA_W+SB_META_W-1:0] entry_d;

  // Next entry: a cleared slot is a bubble with no stale address or load flag.
  always_comb begin
    entry_d = clear_i ? '0 : entry_i;
  end

  // Slot register; reset leaves it invalid, hold keeps the current writer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      entry_q <= '0;
    end else if (!hold_i) begin
      entry_q <= entry_d;
    end
  end

  assign entry_o = entry_q;

endmodule

// File: rtl/hazard_forward_unit.sv
// Decode-side hazard unit: tracks EX/MEM/WB writers, issues registered forward selects and load-use stalls.
// Latency: selects register on the edge the instruction enters EX; stall is combinational from decode.
// Backpressure: pipe_hold freezes all state and forces stall; load-use holds decode for LOAD_STALL cycles.
module hazard_forward_unit
  import hazard_forward_unit_pkg::*;
#(
  parameter int RA_W       = 3,
  parameter int LOAD_STALL = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [RA_W-1:0] id_src_addr,
  input  logic [RA_W-1:0] id_dst_addr,
  input  logic            id_uses_src,
  input  logic            id_uses_dst,
  input  logic            id_wr_en,
  input  logic [RA_W-1:0] id_wr_addr,
  input  logic            id_is_load,
  input  logic            pipe_hold,
  input  logic            flush,
  output logic [1:0]      fu_src_sel,
  output logic [1:0]      fu_dst_sel,
  output logic            stall,
  output logic            ex_bubble
);

  localparam int EW = RA_W + SB_META_W;
  // The first stall cycle is the hazard cycle itself; the counter covers the rest.
  localparam logic [STALL_CNT_W-1:0] STALL_RELOAD = STALL_CNT_W'(LOAD_STALL - 1);

  // Scoreboard slots mirroring the EX, MEM and WB positions.
  logic [EW-1:0] e_q;
  logic [EW-1:0] m_q;
  logic [EW-1:0] w_q;
  logic [EW-1:0] dec_entry;

  logic [STALL_CNT_W-1:0] cnt_q;
  logic [STALL_CNT_W-1:0] cnt_d;
  fwd_sel_e               src_sel_q;
  fwd_sel_e               src_sel_d;
  fwd_sel_e               dst_sel_q;
  fwd_sel_e               dst_sel_d;
  logic                   ex_bubble_q;
  logic                   ex_bubble_d;

  logic            e_vld;
  logic            e_ld;
  logic [RA_W-1:0] e_addr;
  logic            m_vld;
  logic            m_ld;
  logic [RA_W-1:0] m_addr;

  logic src_hit_e;
  logic dst_hit_e;
  logic src_hit_m;
  logic dst_hit_m;
  logic load_use;
  logic cnt_busy;
  logic stall_int;
  logic inject;
  logic e_clear;

  // The WB slot is tracked for pipeline alignment only; writers that far
  // ahead are already visible through register-file write-before-read.
  logic sb_w_unused;
  assign sb_w_unused = ^w_q;

  assign e_vld  = e_q[SB_VALID_BIT];
  assign e_ld   = e_q[SB_LOAD_BIT];
  assign e_addr = e_q[SB_ADDR_LSB +: RA_W];
  assign m_vld  = m_q[SB_VALID_BIT];
  assign m_ld   = m_q[SB_LOAD_BIT];
  assign m_addr = m_q[SB_ADDR_LSB +: RA_W];

  // Operand matches against the writers one (E) and two (M) ahead of decode.
  always_comb begin
    src_hit_e = id_uses_src & e_vld & (e_addr == id_src_addr);
    dst_hit_e = id_uses_dst & e_vld & (e_addr == id_dst_addr);
    src_hit_m = id_uses_src & m_vld & (m_addr == id_src_addr);
    dst_hit_m = id_uses_dst & m_vld & (m_addr == id_dst_addr);
  end

  // Load-use detection and bubble injection; both operands against the same
  // load collapse into one hazard, so only one stall window is opened.
  always_comb begin
    load_use  = e_ld & (src_hit_e | dst_hit_e);
    cnt_busy  = (cnt_q != '0);
    stall_int = cnt_busy | load_use;
    inject    = flush | stall_int | ~id_valid;
    e_clear   = inject | ~id_wr_en;
  end

  assign stall = pipe_hold | stall_int;

  // Decode entry offered to the EX slot; the slot's clear turns it into a bubble.
  assign dec_entry = {id_wr_addr, id_is_load, 1'b1};

  // Stall counter: flush abandons the window, otherwise count down the
  // remaining bubbles or open a new window on a fresh load-use hazard.
  always_comb begin
    cnt_d = '0;
    if (flush) begin
      cnt_d = '0;
    end else if (cnt_busy) begin
      cnt_d = cnt_q - STALL_CNT_W'(1);
    end else if (load_use) begin
      cnt_d = STALL_RELOAD;
    end
  end

  // Forward selects: the newest matching writer wins; bubbles carry no forward.
  always_comb begin
    src_sel_d = FWD_NONE;
    dst_sel_d = FWD_NONE;
    if (!inject) begin
      if (src_hit_e) begin
        src_sel_d = FWD_EM;
      end else if (src_hit_m) begin
        src_sel_d = mw_src_code(m_ld);
      end
      // Operand B has no MEM/WB ALU path, so a two-ahead writer comes off WB.
      if (dst_hit_e) begin
        dst_sel_d = FWD_EM;
      end else if (dst_hit_m) begin
        dst_sel_d = FWD_WB;
      end
    end
  end

  // ex_bubble follows whatever validity the EX slot is loaded with.
  assign ex_bubble_d = e_clear;

  // Registered outputs and stall counter; reset abandons any stall at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      src_sel_q   <= FWD_NONE;
      dst_sel_q   <= FWD_NONE;
      ex_bubble_q <= 1'b1;
      cnt_q       <= '0;
    end else if (!pipe_hold) begin
      src_sel_q   <= src_sel_d;
      dst_sel_q   <= dst_sel_d;
      ex_bubble_q <= ex_bubble_d;
      cnt_q       <= cnt_d;
    end
  end

  assign fu_src_sel = src_sel_q;
  assign fu_dst_sel = dst_sel_q;
  assign ex_bubble  = ex_bubble_q;

  sb_entry_reg #(.RA_W(RA_W)) u_sb_e (
    .clk     (clk),
    .rst     (rst),
    .hold_i  (pipe_hold),
    .clear_i (e_clear),
    .entry_i (dec_entry),
    .entry_o (e_q)
  );

  sb_entry_reg #(.RA_W(RA_W)) u_sb_m (
    .clk     (clk),
    .rst     (rst),
    .hold_i  (pipe_hold),
    .clear_i (1'b0),
    .entry_i (e_q),
    .entry_o (m_q)
  );

  sb_entry_reg #(.RA_W(RA_W)) u_sb_w (
    .clk     (clk),
    .rst     (rst),
    .hold_i  (pipe_hold),
    .clear_i (1'b0),
    .entry_i (m_q),
    .entry_o (w_q)
  );

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Bench for hazard_forward_unit: two instances (LOAD_STALL=1 and 2) on shared stimulus.
// Latency: inputs at negedge, stall sampled 1ns later, registered outputs sampled 1ns after posedge.
// Backpressure: decode instruction is re-presented while the reference model says stall.
module tb_hazard_forward_unit;

  logic       clk;
  logic       rst;
  logic       id_valid;
  logic [2:0] id_src_addr;
  logic [2:0] id_dst_addr;
  logic       id_uses_src;
  logic       id_uses_dst;
  logic       id_wr_en;
  logic [2:0] id_wr_addr;
  logic       id_is_load;
  logic       pipe_hold;
  logic       flush;

  logic [1:0] src_o [2];
  logic [1:0] dst_o [2];
  logic       stall_o [2];
  logic       bub_o [2];

  hazard_forward_unit #(.RA_W(3), .LOAD_STALL(1)) u_dut_ls1 (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_src_addr(id_src_addr), .id_dst_addr(id_dst_addr),
    .id_uses_src(id_uses_src), .id_uses_dst(id_uses_dst),
    .id_wr_en(id_wr_en), .id_wr_addr(id_wr_addr), .id_is_load(id_is_load),
    .pipe_hold(pipe_hold), .flush(flush),
    .fu_src_sel(src_o[0]), .fu_dst_sel(dst_o[0]), .stall(stall_o[0]), .ex_bubble(bub_o[0])
  );

  hazard_forward_unit #(.RA_W(3), .LOAD_STALL(2)) u_dut_ls2 (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_src_addr(id_src_addr), .id_dst_addr(id_dst_addr),
    .id_uses_src(id_uses_src), .id_uses_dst(id_uses_dst),
    .id_wr_en(id_wr_en), .id_wr_addr(id_wr_addr), .id_is_load(id_is_load),
    .pipe_hold(pipe_hold), .flush(flush),
    .fu_src_sel(src_o[1]), .fu_dst_sel(dst_o[1]), .stall(stall_o[1]), .ex_bubble(bub_o[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_bad;

  // Reference model: writers indexed by distance ahead of decode (0 = one
  // instruction ahead), plus the number of owed stall cycles still to come.
  int         ls_cfg [2] = '{1, 2};
  logic       wv  [2][3];
  logic [2:0] wa_h [2][3];
  logic       wl  [2][3];
  int         owed [2];
  int         exp_src [2];
  int         exp_dst [2];
  int         exp_bub [2];
  logic       smp_stall [2];
  logic       mdl_stall0;

  task automatic chk(input string tag, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 3; j++) begin
        wv[k][j]   = 1'b0;
        wa_h[k][j] = 3'd0;
        wl[k][j]   = 1'b0;
      end
      owed[k]    = 0;
      exp_src[k] = 0;
      exp_dst[k] = 0;
      exp_bub[k] = 1;
    end
  endtask

  // One pipeline cycle: drive decode, check stall, advance model, check registered outputs.
  task automatic step(input logic v, input logic [2:0] s, input logic [2:0] d,
                      input logic us, input logic ud, input logic we,
                      input logic [2:0] wa, input logic ld,
                      input logic hold, input logic fl);
    logic lu;
    logic st;
    logic inj;
    int   ns;
    int   nd;
    @(negedge clk);
    id_valid = v; id_src_addr = s; id_dst_addr = d;
    id_uses_src = us; id_uses_dst = ud; id_wr_en = we;
    id_wr_addr = wa; id_is_load = ld; pipe_hold = hold; flush = fl;
    #1;
    for (int k = 0; k < 2; k++) begin
      lu = wv[k][0] && wl[k][0] && ((us && wa_h[k][0] == s) || (ud && wa_h[k][0] == d));
      st = hold || (owed[k] > 0) || lu;
      smp_stall[k] = stall_o[k];
      chk($sformatf("stall_ls%0d", ls_cfg[k]), int'(stall_o[k]), int'(st));
      if (k == 0) mdl_stall0 = st;
      if (!hold) begin
        inj = fl || (owed[k] > 0) || lu || !v;
        ns = 0;
        nd = 0;
        if (!inj) begin
          if (us && wv[k][0] && wa_h[k][0] == s)      ns = 2;
          else if (us && wv[k][1] && wa_h[k][1] == s) ns = wl[k][1] ? 1 : 3;
          if (ud && wv[k][0] && wa_h[k][0] == d)      nd = 2;
          else if (ud && wv[k][1] && wa_h[k][1] == d) nd = 1;
        end
        for (int j = 2; j > 0; j--) begin
          wv[k][j] = wv[k][j-1]; wa_h[k][j] = wa_h[k][j-1]; wl[k][j] = wl[k][j-1];
        end
        wv[k][0] = v && we && !inj;
        wa_h[k][0] = wa;
        wl[k][0] = ld;
        exp_src[k] = ns;
        exp_dst[k] = nd;
        exp_bub[k] = wv[k][0] ? 0 : 1;
        if (fl)               owed[k] = 0;
        else if (owed[k] > 0) owed[k] = owed[k] - 1;
        else if (lu)          owed[k] = ls_cfg[k] - 1;
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("src_ls%0d", ls_cfg[k]), int'(src_o[k]), exp_src[k]);
      chk($sformatf("dst_ls%0d", ls_cfg[k]), int'(dst_o[k]), exp_dst[k]);
      chk($sformatf("bub_ls%0d", ls_cfg[k]), int'(bub_o[k]), exp_bub[k]);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
  endtask

  logic       r_v, r_us, r_ud, r_we, r_ld, r_hold, r_fl;
  logic [2:0] r_s, r_d, r_wa;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b0;
    id_valid = 1'b0; id_src_addr = 3'd0; id_dst_addr = 3'd0;
    id_uses_src = 1'b0; id_uses_dst = 1'b0; id_wr_en = 1'b0;
    id_wr_addr = 3'd0; id_is_load = 1'b0; pipe_hold = 1'b0; flush = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_src", int'(src_o[k]), 0);
      chk("rst_dst", int'(dst_o[k]), 0);
      chk("rst_bub", int'(bub_o[k]), 1);
      chk("rst_stall", int'(stall_o[k]), 0);
    end
    rst = 1'b1;

    // ADD R1 ; ADD R2,R1 -> EX/MEM forward, no stall.
    idle(3);
    step(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 3'd1, 3'd4, 1'b1, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0);
    chk("b2b_src", int'(src_o[0]), 2);
    chk("b2b_stall", int'(smp_stall[0]), 0);
    // Hold three cycles with a dependent op in decode: outputs frozen, stall forced.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 3'd2, 3'd0, 1'b1, 1'b0, 1'b1, 3'd3, 1'b0, 1'b1, 1'b0);
      chk("hold_stall", int'(smp_stall[0]), 1);
      chk("hold_src", int'(src_o[0]), 2);
    end
    step(1'b1, 3'd2, 3'd0, 1'b1, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0);
    chk("post_hold_src", int'(src_o[0]), 2);
    chk("post_hold_stall", int'(smp_stall[0]), 0);

    // ADD R3 ; NOP ; SUB R4,R3 with R3 on operand B -> WB bus on B only.
    idle(3);
    step(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0);
    step(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 3'd5, 3'd3, 1'b1, 1'b1, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0);
    chk("m_dst_dst", int'(dst_o[0]), 1);
    chk("m_dst_src", int'(src_o[0]), 0);

    // ADD R5 ; NOP ; OR with R5 as Rsrc -> MEM/WB ALU forward.
    idle(3);
    step(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd5, 1'b0, 1'b0, 1'b0);
    step(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 3'd5, 3'd1, 1'b1, 1'b0, 1'b1, 3'd6, 1'b0, 1'b0, 1'b0);
    chk("m_src_src", int'(src_o[0]), 3);

    // R0 is an ordinary register.
    idle(3);
    step(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 3'd7, 3'd0, 1'b0, 1'b1, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0);
    chk("r0_dst", int'(dst_o[0]), 2);

    // LDD R6 ; ADD R7,R6 (both operands) -> one window of LOAD_STALL bubbles.
    idle(3);
    step(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd6, 1'b1, 1'b0, 1'b0);
    step(1'b1, 3'd6, 3'd6, 1'b1, 1'b1, 1'b1, 3'd7, 1'b0, 1'b0, 1'b0);
    chk("lu1_stall", int'(smp_stall[0]), 1);
    chk("lu1_bub", int'(bub_o[0]), 1);
    chk("lu2_stall_a", int'(smp_stall[1]), 1);
    step(1'b1, 3'd6, 3'd6, 1'b1, 1'b1, 1'b1, 3'd7, 1'b0, 1'b0, 1'b0);
    chk("lu1_resolve_stall", int'(smp_stall[0]), 0);
    chk("lu1_resolve_src", int'(src_o[0]), 1);
    chk("lu1_resolve_dst", int'(dst_o[0]), 1);
    chk("lu2_stall_b", int'(smp_stall[1]), 1);
    chk("lu2_bub_b", int'(bub_o[1]), 1);
    step(1'b1, 3'd6, 3'd6, 1'b1, 1'b1, 1'b1, 3'd7, 1'b0, 1'b0, 1'b0);
    chk("lu2_resolve_stall", int'(smp_stall[1]), 0);
    chk("lu2_resolve_src", int'(src_o[1]), 0);

    // Load-use with flush in the same cycle: window abandoned.
    idle(3);
    step(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd6, 1'b1, 1'b0, 1'b0);
    step(1'b1, 3'd6, 3'd0, 1'b1, 1'b0, 1'b1, 3'd7, 1'b0, 1'b0, 1'b1);
    chk("fl_bub", int'(bub_o[1]), 1);
    chk("fl_src", int'(src_o[1]), 0);
    step(1'b1, 3'd6, 3'd0, 1'b1, 1'b0, 1'b1, 3'd7, 1'b0, 1'b0, 1'b0);
    chk("fl_after_stall_ls2", int'(smp_stall[1]), 0);
    chk("fl_after_src_ls2", int'(src_o[1]), 1);

    // Asynchronous reset in the middle of a load-use stall.
    idle(3);
    step(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd6, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    id_valid = 1'b1; id_src_addr = 3'd6; id_uses_src = 1'b1; id_uses_dst = 1'b0;
    id_wr_en = 1'b1; id_wr_addr = 3'd7; id_is_load = 1'b0; pipe_hold = 1'b0; flush = 1'b0;
    #1;
    chk("pre_rst_stall", int'(stall_o[1]), 1);
    rst = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("arst_stall", int'(stall_o[k]), 0);
      chk("arst_src", int'(src_o[k]), 0);
      chk("arst_dst", int'(dst_o[k]), 0);
      chk("arst_bub", int'(bub_o[k]), 1);
    end
    model_reset();
    @(negedge clk);
    id_valid = 1'b0; id_uses_src = 1'b0; id_wr_en = 1'b0;
    rst = 1'b1;

    // Randomized traffic; a stalled decode instruction is re-presented.
    mdl_stall0 = 1'b0;
    r_fl = 1'b0;
    r_v = 1'b0; r_s = 3'd0; r_d = 3'd0; r_us = 1'b0; r_ud = 1'b0;
    r_we = 1'b0; r_wa = 3'd0; r_ld = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if (!(mdl_stall0 && !r_fl)) begin
        r_v  = ($urandom % 8) != 0;
        r_s  = 3'($urandom % 4);
        r_d  = 3'($urandom % 4);
        r_us = 1'($urandom % 2);
        r_ud = 1'($urandom % 2);
        r_we = ($urandom % 5) != 0;
        r_wa = 3'($urandom % 4);
        r_ld = ($urandom % 10) < 3;
      end
      r_hold = ($urandom % 10) == 0;
      r_fl   = ($urandom % 12) == 0;
      step(r_v, r_s, r_d, r_us, r_ud, r_we, r_wa, r_ld, r_hold, r_fl);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
